// File: rtl/udp_axis_master_mc_pkg.sv
// Shared types and helpers for the multi-channel UDP to AXI-Stream master.
package udp_axis_pkg;

   localparam int unsigned UDP_HDR_BYTES       = 8;
   localparam int unsigned REPLY_TRAILER_BYTES = 3;

   typedef enum logic [2:0] {
      RX_HEADER  = 3'd0,
      RX_DISCARD = 3'd1,
      RX_ID      = 3'd2,
      RX_DATA    = 3'd3,
      TX_HEADER  = 3'd4,
      TX_PAYLOAD = 3'd5
   } state_t;

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

   typedef enum logic [7:0] {
      OK        = 8'h00,
      SHORT     = 8'h01,
      BAD_FRAME = 8'h03
   } status_t;

   typedef struct packed {
      logic [31:0] ip_src;
      logic [31:0] ip_dst;
      logic [15:0] port_src;
      logic [15:0] port_dst;
   } udp_addr_t;

   // UDP length of a reply: header + echoed ID + status + 16-bit count
   function automatic logic [15:0] reply_len(input int unsigned id_bytes);
      return 16'(UDP_HDR_BYTES + id_bytes + REPLY_TRAILER_BYTES);
   endfunction

endpackage

// File: rtl/udp_axis_master_mc_if.sv
// Bus interfaces: generic AXI-Stream plus UDP receive/transmit header channels.
interface AXIS_IF #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEST_W = 1
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;
   logic              tuser;
   logic [DEST_W-1:0] tdest;

   modport Master (output tvalid, tdata, tlast, tuser, tdest, input tready);
   modport Slave  (input tvalid, tdata, tlast, tuser, tdest, output tready);
endinterface

interface UDP_RX_HEADER_IF;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [31:0] ip_src;
   logic [31:0] ip_dst;
   logic [15:0] port_src;
   logic [15:0] port_dst;

   modport Source (output hdr_valid, ip_src, ip_dst, port_src, port_dst, input hdr_ready);
   modport Sink   (input hdr_valid, ip_src, ip_dst, port_src, port_dst, output hdr_ready);
endinterface

interface UDP_TX_HEADER_IF;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [5:0]  dscp;
   logic [1:0]  ecn;
   logic [7:0]  ttl;
   logic [31:0] ip_src;
   logic [31:0] ip_dst;
   logic [15:0] port_src;
   logic [15:0] port_dst;
   logic [15:0] length;
   logic [15:0] checksum;

   modport Source (output hdr_valid, dscp, ecn, ttl, ip_src, ip_dst, port_src, port_dst,
                   length, checksum, input hdr_ready);
   modport Sink   (input hdr_valid, dscp, ecn, ttl, ip_src, ip_dst, port_src, port_dst,
                   length, checksum, output hdr_ready);
endinterface

// File: rtl/udp_axis_master_mc_reply_serializer.sv
// Streams the reply payload: ID bytes (LSB first), status, count MSB, count LSB.
module udp_axis_reply_serializer
   import udp_axis_pkg::*;
#(
   parameter int unsigned ID_BYTES = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_start,
   input  logic [ID_BYTES*8-1:0] i_id,
   input  logic [7:0]            i_status,
   input  logic [15:0]           i_count,
   AXIS_IF.Master                tx_if,
   output logic                  o_done
);
   localparam int unsigned BEATS  = ID_BYTES + REPLY_TRAILER_BYTES;
   localparam int unsigned BEAT_W = $clog2(BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   ser_state_t        r_state, w_state_nxt;
   logic [BEAT_W-1:0] r_beat, w_beat_nxt, w_beat_inc;
   logic              r_tvalid, w_tvalid_nxt;
   logic [7:0]        r_tdata, w_tdata_nxt;
   logic              r_tlast, w_tlast_nxt;
   logic              r_done, w_done_nxt;

   function automatic logic [7:0] byte_at(input logic [BEAT_W-1:0] beat,
                                          input logic [ID_BYTES*8-1:0] id,
                                          input logic [7:0] status,
                                          input logic [15:0] count);
      if (32'(beat) < ID_BYTES)           return id[{beat, 3'b000} +: 8];
      else if (32'(beat) == ID_BYTES)     return status;
      else if (32'(beat) == ID_BYTES + 1) return count[15:8];
      else                                return count[7:0];
   endfunction

   assign w_beat_inc = r_beat + BEAT_W'(1);

   // State and registered beat outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= SER_IDLE;
         r_beat   <= '0;
         r_tvalid <= 1'b0;
         r_tdata  <= 8'h00;
         r_tlast  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_beat   <= w_beat_nxt;
         r_tvalid <= w_tvalid_nxt;
         r_tdata  <= w_tdata_nxt;
         r_tlast  <= w_tlast_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Advance one beat per handshake; data held while stalled
   always_comb begin
      w_state_nxt  = r_state;
      w_beat_nxt   = r_beat;
      w_tvalid_nxt = r_tvalid;
      w_tdata_nxt  = r_tdata;
      w_tlast_nxt  = r_tlast;
      w_done_nxt   = 1'b0;
      unique case (r_state)
         SER_IDLE: begin
            if (i_start) begin
               w_state_nxt  = SER_SEND;
               w_beat_nxt   = '0;
               w_tvalid_nxt = 1'b1;
               w_tdata_nxt  = byte_at(BEAT_W'(0), i_id, i_status, i_count);
               w_tlast_nxt  = 1'b0;
            end
         end
         SER_SEND: begin
            if (tx_if.tready) begin
               if (r_tlast) begin
                  w_state_nxt  = SER_IDLE;
                  w_tvalid_nxt = 1'b0;
                  w_tlast_nxt  = 1'b0;
                  w_done_nxt   = 1'b1;
               end else begin
                  w_beat_nxt  = w_beat_inc;
                  w_tdata_nxt = byte_at(w_beat_inc, i_id, i_status, i_count);
                  w_tlast_nxt = (w_beat_inc == LAST_BEAT);
               end
            end
         end
         default: w_state_nxt = SER_IDLE;
      endcase
   end

   assign tx_if.tvalid = r_tvalid;
   assign tx_if.tdata  = r_tdata;
   assign tx_if.tlast  = r_tlast;
   assign tx_if.tuser  = 1'b0;
   assign tx_if.tdest  = '0;
   assign o_done       = r_done;

endmodule

// File: rtl/udp_axis_master_mc.sv
// Multi-channel UDP-to-AXI-Stream master: strips a transfer ID, forwards data
// tagged with the channel, and answers every accepted datagram with a reply.
module udp_axis_master_mc
   import udp_axis_pkg::*;
#(
   parameter int unsigned BASE_PORT    = 4321,
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned ID_BYTES     = 6,
   parameter int unsigned REPLY_TTL    = 64
) (
   input  logic           clk,
   input  logic           reset,
   UDP_RX_HEADER_IF.Sink  udp_rx_header_if,
   AXIS_IF.Slave          udp_rx_payload_if,
   UDP_TX_HEADER_IF.Source udp_tx_header_if,
   AXIS_IF.Master         udp_tx_payload_if,
   AXIS_IF.Master         out_axis_if,
   output logic [31:0]    drop_count
);
   localparam int unsigned DEST_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int unsigned IDX_W  = (ID_BYTES > 1) ? $clog2(ID_BYTES) : 1;
   localparam int unsigned ID_W   = ID_BYTES * 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ID_BYTES - 1);

   state_t            r_state, w_state_nxt;
   logic              r_hdr_ready, w_hdr_ready_nxt;
   udp_addr_t         r_addr, w_addr_nxt;
   logic [DEST_W-1:0] r_channel, w_channel_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [15:0]       r_byte_count, w_byte_count_nxt;
   logic [ID_W-1:0]   r_id, w_id_nxt;
   status_t           r_status, w_status_nxt;
   logic [31:0]       r_drop_count, w_drop_count_nxt;
   logic              r_tx_hdr_valid, w_tx_hdr_valid_nxt;
   logic              r_start, w_start_nxt;

   logic [15:0] w_port_off;
   logic        w_in_window, w_hdr_hs, w_rx_hs, w_tx_hdr_hs, w_rx_tready, w_ser_done;
   logic        w_unused_rx_tdest;

   assign w_port_off  = udp_rx_header_if.port_dst - 16'(BASE_PORT);
   assign w_in_window = (w_port_off < 16'(NUM_CHANNELS));
   assign w_hdr_hs    = udp_rx_header_if.hdr_valid && r_hdr_ready;
   assign w_rx_hs     = udp_rx_payload_if.tvalid && w_rx_tready;
   assign w_tx_hdr_hs = r_tx_hdr_valid && udp_tx_header_if.hdr_ready;
   assign w_unused_rx_tdest = ^udp_rx_payload_if.tdest;

   // Payload ready: always in ID/discard, follows the fabric while forwarding
   always_comb begin
      w_rx_tready = 1'b0;
      unique case (r_state)
         RX_ID, RX_DISCARD: w_rx_tready = 1'b1;
         RX_DATA:           w_rx_tready = out_axis_if.tready;
         default:           w_rx_tready = 1'b0;
      endcase
   end

   assign udp_rx_payload_if.tready = w_rx_tready;
   assign udp_rx_header_if.hdr_ready = r_hdr_ready;

   // Data passthrough is combinational so forwarding costs no bubble
   assign out_axis_if.tvalid = (r_state == RX_DATA) && udp_rx_payload_if.tvalid;
   assign out_axis_if.tdata  = udp_rx_payload_if.tdata;
   assign out_axis_if.tlast  = udp_rx_payload_if.tlast;
   assign out_axis_if.tuser  = udp_rx_payload_if.tuser;
   assign out_axis_if.tdest  = r_channel;

   // Reply header goes back to the sender with addresses swapped
   assign udp_tx_header_if.hdr_valid = r_tx_hdr_valid;
   assign udp_tx_header_if.dscp      = 6'd0;
   assign udp_tx_header_if.ecn       = 2'd0;
   assign udp_tx_header_if.ttl       = 8'(REPLY_TTL);
   assign udp_tx_header_if.ip_src    = r_addr.ip_dst;
   assign udp_tx_header_if.ip_dst    = r_addr.ip_src;
   assign udp_tx_header_if.port_src  = r_addr.port_dst;
   assign udp_tx_header_if.port_dst  = r_addr.port_src;
   assign udp_tx_header_if.length    = reply_len(ID_BYTES);
   assign udp_tx_header_if.checksum  = 16'd0;

   assign drop_count = r_drop_count;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= RX_HEADER;
         r_hdr_ready    <= 1'b0;
         r_addr         <= '0;
         r_channel      <= '0;
         r_idx          <= '0;
         r_byte_count   <= 16'd0;
         r_id           <= '0;
         r_status       <= OK;
         r_drop_count   <= 32'd0;
         r_tx_hdr_valid <= 1'b0;
         r_start        <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_hdr_ready    <= w_hdr_ready_nxt;
         r_addr         <= w_addr_nxt;
         r_channel      <= w_channel_nxt;
         r_idx          <= w_idx_nxt;
         r_byte_count   <= w_byte_count_nxt;
         r_id           <= w_id_nxt;
         r_status       <= w_status_nxt;
         r_drop_count   <= w_drop_count_nxt;
         r_tx_hdr_valid <= w_tx_hdr_valid_nxt;
         r_start        <= w_start_nxt;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt        = r_state;
      w_hdr_ready_nxt    = r_hdr_ready;
      w_addr_nxt         = r_addr;
      w_channel_nxt      = r_channel;
      w_idx_nxt          = r_idx;
      w_byte_count_nxt   = r_byte_count;
      w_id_nxt           = r_id;
      w_status_nxt       = r_status;
      w_drop_count_nxt   = r_drop_count;
      w_tx_hdr_valid_nxt = r_tx_hdr_valid;
      w_start_nxt        = 1'b0;
      unique case (r_state)
         RX_HEADER: begin
            if (w_hdr_hs) begin
               w_hdr_ready_nxt = 1'b0;
               w_addr_nxt = '{ip_src:   udp_rx_header_if.ip_src,
                              ip_dst:   udp_rx_header_if.ip_dst,
                              port_src: udp_rx_header_if.port_src,
                              port_dst: udp_rx_header_if.port_dst};
               w_id_nxt = '0;
               if (w_in_window) begin
                  w_channel_nxt    = DEST_W'(w_port_off);
                  w_idx_nxt        = '0;
                  w_byte_count_nxt = 16'd0;
                  w_state_nxt      = RX_ID;
               end else begin
                  if (r_drop_count != 32'hFFFF_FFFF) w_drop_count_nxt = r_drop_count + 32'd1;
                  w_state_nxt = RX_DISCARD;
               end
            end else begin
               w_hdr_ready_nxt = 1'b1;
            end
         end
         RX_DISCARD: begin
            if (w_rx_hs && udp_rx_payload_if.tlast) w_state_nxt = RX_HEADER;
         end
         RX_ID: begin
            if (w_rx_hs) begin
               w_id_nxt[{r_idx, 3'b000} +: 8] = udp_rx_payload_if.tdata;
               w_idx_nxt = r_idx + IDX_W'(1);
               if (udp_rx_payload_if.tlast) begin
                  w_status_nxt       = (r_idx == LAST_IDX) ? OK : SHORT;
                  w_tx_hdr_valid_nxt = 1'b1;
                  w_state_nxt        = TX_HEADER;
               end else if (r_idx == LAST_IDX) begin
                  w_state_nxt = RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (w_rx_hs) begin
               if (r_byte_count != 16'hFFFF) w_byte_count_nxt = r_byte_count + 16'd1;
               if (udp_rx_payload_if.tlast) begin
                  w_status_nxt       = udp_rx_payload_if.tuser ? BAD_FRAME : OK;
                  w_tx_hdr_valid_nxt = 1'b1;
                  w_state_nxt        = TX_HEADER;
               end
            end
         end
         TX_HEADER: begin
            if (w_tx_hdr_hs) begin
               w_tx_hdr_valid_nxt = 1'b0;
               w_start_nxt        = 1'b1;
               w_state_nxt        = TX_PAYLOAD;
            end
         end
         TX_PAYLOAD: begin
            if (w_ser_done) w_state_nxt = RX_HEADER;
         end
         default: w_state_nxt = RX_HEADER;
      endcase
   end

   udp_axis_reply_serializer #(.ID_BYTES(ID_BYTES)) u_reply_serializer (
      .clk      (clk),
      .reset    (reset),
      .i_start  (r_start),
      .i_id     (r_id),
      .i_status (8'(r_status)),
      .i_count  (r_byte_count),
      .tx_if    (udp_tx_payload_if),
      .o_done   (w_ser_done)
   );

endmodule

// File: tb/tb_udp_axis_master_mc.sv
// Scoreboard bench: a datagram-level model predicts forwarded beats and replies,
// independent monitors pop and compare whatever the DUT presents.
module tb_udp_axis_master_mc;
   localparam int unsigned BASE_PORT = 4321;
   localparam int unsigned NUM_CH    = 4;
   localparam int unsigned ID_BYTES  = 6;
   localparam int unsigned REPLY_TTL = 64;
   localparam int unsigned DEST_W    = 2;
   localparam int          TIMEOUT   = 4000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] drop_count;

   always #5 clk = ~clk;

   UDP_RX_HEADER_IF                          rx_hdr ();
   AXIS_IF #(.DATA_W(8), .DEST_W(1))         rx_pl ();
   UDP_TX_HEADER_IF                          tx_hdr ();
   AXIS_IF #(.DATA_W(8), .DEST_W(1))         tx_pl ();
   AXIS_IF #(.DATA_W(8), .DEST_W(DEST_W))    out_s ();

   udp_axis_master_mc #(
      .BASE_PORT(BASE_PORT), .NUM_CHANNELS(NUM_CH), .ID_BYTES(ID_BYTES), .REPLY_TTL(REPLY_TTL)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .udp_rx_header_if  (rx_hdr),
      .udp_rx_payload_if (rx_pl),
      .udp_tx_header_if  (tx_hdr),
      .udp_tx_payload_if (tx_pl),
      .out_axis_if       (out_s),
      .drop_count        (drop_count)
   );

   typedef struct { logic [7:0] data; logic last; logic user; logic [DEST_W-1:0] dest; } out_beat_t;
   typedef struct { logic [31:0] ip_src; logic [31:0] ip_dst; logic [15:0] port_src; logic [15:0] port_dst; } hdr_exp_t;
   typedef struct { logic [7:0] data; logic last; } tx_beat_t;

   out_beat_t   out_q[$];
   hdr_exp_t    hdr_q[$];
   tx_beat_t    tx_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          sb_ignore = 1'b0;
   int          tx_beats_seen = 0;
   longint      model_drops = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: got %s", name, what);
   endtask

   // Random backpressure on all downstream ready signals
   initial begin
      out_s.tready = 1'b0;
      tx_hdr.hdr_ready = 1'b0;
      tx_pl.tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_s.tready     = 1'($urandom % 2);
         tx_hdr.hdr_ready = 1'($urandom % 2);
         tx_pl.tready     = ($urandom % 4) != 0;
      end
   end

   // Forwarded-data monitor
   initial begin
      out_beat_t e;
      forever begin
         @(negedge clk);
         if (!reset && !sb_ignore && out_s.tvalid && out_s.tready) begin
            if (out_q.size() == 0) fail_now("out_beat", "unexpected beat, expected none");
            else begin
               e = out_q.pop_front();
               check("out_tdata", 64'(out_s.tdata), 64'(e.data));
               check("out_tlast", 64'(out_s.tlast), 64'(e.last));
               check("out_tuser", 64'(out_s.tuser), 64'(e.user));
               check("out_tdest", 64'(out_s.tdest), 64'(e.dest));
            end
         end
      end
   end

   // Reply header monitor
   initial begin
      hdr_exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && !sb_ignore && tx_hdr.hdr_valid && tx_hdr.hdr_ready) begin
            if (hdr_q.size() == 0) fail_now("tx_hdr", "unexpected reply header, expected none");
            else begin
               e = hdr_q.pop_front();
               check("tx_ip_src",   64'(tx_hdr.ip_src),   64'(e.ip_src));
               check("tx_ip_dst",   64'(tx_hdr.ip_dst),   64'(e.ip_dst));
               check("tx_port_src", 64'(tx_hdr.port_src), 64'(e.port_src));
               check("tx_port_dst", 64'(tx_hdr.port_dst), 64'(e.port_dst));
               check("tx_length",   64'(tx_hdr.length),   64'(8 + ID_BYTES + 3));
               check("tx_ttl",      64'(tx_hdr.ttl),      64'(REPLY_TTL));
               check("tx_dscp_ecn", 64'({tx_hdr.dscp, tx_hdr.ecn}), 64'(0));
               check("tx_checksum", 64'(tx_hdr.checksum), 64'(0));
            end
         end
      end
   end

   // Reply payload monitor
   initial begin
      tx_beat_t e;
      forever begin
         @(negedge clk);
         if (!reset && tx_pl.tvalid && tx_pl.tready) begin
            tx_beats_seen++;
            if (!sb_ignore) begin
               if (tx_q.size() == 0) fail_now("tx_beat", "unexpected reply beat, expected none");
               else begin
                  e = tx_q.pop_front();
                  check("tx_tdata", 64'(tx_pl.tdata), 64'(e.data));
                  check("tx_tlast", 64'(tx_pl.tlast), 64'(e.last));
                  check("tx_tuser", 64'(tx_pl.tuser), 64'(0));
               end
            end
         end
      end
   end

   // Datagram-level reference: what the design must emit for one datagram
   task automatic model_datagram(input int port, input logic [31:0] sip, input logic [31:0] dip,
                                 input logic [15:0] sport, input logic [7:0] bytes[$], input bit user_last);
      int n = bytes.size();
      int cnt;
      int status;
      if (port < int'(BASE_PORT) || port >= int'(BASE_PORT + NUM_CH)) begin
         if (model_drops < 64'hFFFF_FFFF) model_drops++;
         return;
      end
      cnt    = (n > int'(ID_BYTES)) ? n - int'(ID_BYTES) : 0;
      if (cnt > 65535) cnt = 65535;
      status = (n < int'(ID_BYTES)) ? 1 : ((n > int'(ID_BYTES) && user_last) ? 3 : 0);
      for (int k = int'(ID_BYTES); k < n; k++)
         out_q.push_back('{data: bytes[k], last: (k == n - 1), user: (user_last && k == n - 1),
                           dest: DEST_W'(port - int'(BASE_PORT))});
      hdr_q.push_back('{ip_src: dip, ip_dst: sip, port_src: 16'(port), port_dst: sport});
      for (int k = 0; k < int'(ID_BYTES); k++)
         tx_q.push_back('{data: (k < n) ? bytes[k] : 8'h00, last: 1'b0});
      tx_q.push_back('{data: 8'(status), last: 1'b0});
      tx_q.push_back('{data: 8'(cnt >> 8), last: 1'b0});
      tx_q.push_back('{data: 8'(cnt), last: 1'b1});
   endtask

   task automatic send_header(input int port, input logic [31:0] sip, input logic [31:0] dip,
                              input logic [15:0] sport);
      bit done = 1'b0;
      rx_hdr.hdr_valid = 1'b1;
      rx_hdr.ip_src    = sip;
      rx_hdr.ip_dst    = dip;
      rx_hdr.port_src  = sport;
      rx_hdr.port_dst  = 16'(port);
      for (int n = 0; n < TIMEOUT && !done; n++) begin
         @(negedge clk);
         if (rx_hdr.hdr_ready) done = 1'b1;
      end
      if (!done) fail_now("hdr_accept_timeout", "hdr_ready never asserted");
      @(posedge clk);
      #1;
      rx_hdr.hdr_valid = 1'b0;
   endtask

   task automatic send_payload(input logic [7:0] bytes[$], input bit mark_last, input bit user_last);
      bit done;
      for (int i = 0; i < bytes.size(); i++) begin
         if ($urandom % 4 == 0) begin
            rx_pl.tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         rx_pl.tvalid = 1'b1;
         rx_pl.tdata  = bytes[i];
         rx_pl.tlast  = mark_last && (i == bytes.size() - 1);
         rx_pl.tuser  = user_last && (i == bytes.size() - 1);
         done = 1'b0;
         for (int n = 0; n < TIMEOUT && !done; n++) begin
            @(negedge clk);
            if (rx_pl.tready) done = 1'b1;
         end
         if (!done) begin
            fail_now("payload_timeout", "tready never asserted");
            break;
         end
         @(posedge clk);
         #1;
      end
      rx_pl.tvalid = 1'b0;
      rx_pl.tlast  = 1'b0;
      rx_pl.tuser  = 1'b0;
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int n = 0; n < TIMEOUT && !done; n++) begin
         @(negedge clk);
         if (out_q.size() == 0 && hdr_q.size() == 0 && tx_q.size() == 0) done = 1'b1;
      end
      if (!done) fail_now("drain_timeout", $sformatf("out %0d hdr %0d tx %0d pending",
                                                     out_q.size(), hdr_q.size(), tx_q.size()));
      @(posedge clk);
      #1;
   endtask

   task automatic run_datagram(input int port, input logic [7:0] bytes[$], input bit user_last);
      logic [31:0] sip = $urandom;
      logic [31:0] dip = $urandom;
      logic [15:0] sport = 16'($urandom);
      model_datagram(port, sip, dip, sport, bytes, user_last);
      send_header(port, sip, dip, sport);
      send_payload(bytes, 1'b1, user_last);
      wait_drain();
      check("drop_count", 64'(drop_count), 64'(model_drops));
   endtask

   task automatic reset_checks(input string tag);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hdr_ready"},    64'(rx_hdr.hdr_ready), 64'(0));
      check({tag, "_tx_hdr_valid"}, 64'(tx_hdr.hdr_valid), 64'(0));
      check({tag, "_tx_tvalid"},    64'(tx_pl.tvalid),     64'(0));
      check({tag, "_tx_tlast"},     64'(tx_pl.tlast),      64'(0));
      check({tag, "_out_tvalid"},   64'(out_s.tvalid),     64'(0));
      check({tag, "_drop_count"},   64'(drop_count),       64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_q.delete();
      hdr_q.delete();
      tx_q.delete();
      model_drops = 0;
      sb_ignore = 1'b0;
   endtask

   initial begin
      logic [7:0] pl[$];
      bit         done;
      int         base;

      reset = 1'b1;
      rx_hdr.hdr_valid = 1'b0;
      rx_hdr.ip_src = '0; rx_hdr.ip_dst = '0; rx_hdr.port_src = '0; rx_hdr.port_dst = '0;
      rx_pl.tvalid = 1'b0; rx_pl.tdata = '0; rx_pl.tlast = 1'b0; rx_pl.tuser = 1'b0; rx_pl.tdest = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hdr_ready",    64'(rx_hdr.hdr_ready), 64'(0));
      check("rst_tx_hdr_valid", 64'(tx_hdr.hdr_valid), 64'(0));
      check("rst_tx_tvalid",    64'(tx_pl.tvalid),     64'(0));
      check("rst_tx_tuser",     64'(tx_pl.tuser),      64'(0));
      check("rst_out_tvalid",   64'(out_s.tvalid),     64'(0));
      check("rst_drop_count",   64'(drop_count),       64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("hdr_ready_after_entry", 64'(rx_hdr.hdr_ready), 64'(1));
      @(posedge clk);
      #1;

      // Basic datagram on channel 0
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_datagram(4321, pl, 1'b0);

      // Long datagram on channel 3 under backpressure
      pl.delete();
      for (int i = 0; i < 306; i++) pl.push_back(8'($urandom));
      run_datagram(4324, pl, 1'b0);

      // Out-of-window port is dropped, then normal traffic resumes
      pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      run_datagram(4325, pl, 1'b0);
      pl = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h99};
      run_datagram(4322, pl, 1'b0);

      // Short ID and exact-ID datagrams
      pl = '{8'h01, 8'h02, 8'h03};
      run_datagram(4323, pl, 1'b0);
      pl = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
      run_datagram(4321, pl, 1'b1);

      // Bad frame after two data bytes
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hE1, 8'hE2};
      run_datagram(4322, pl, 1'b1);

      // Reset in the middle of forwarding
      sb_ignore = 1'b1;
      send_header(4322, 32'h0A000001, 32'h0A000002, 16'd5000);
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h10, 8'h11, 8'h12};
      send_payload(pl, 1'b0, 1'b0);
      reset = 1'b1;
      reset_checks("rst_rxdata");
      pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h40, 8'h41};
      run_datagram(4323, pl, 1'b0);

      // Reset in the middle of the reply payload
      pl = '{8'h01};
      run_datagram(4400, pl, 1'b0);
      sb_ignore = 1'b1;
      base = tx_beats_seen;
      send_header(4321, 32'h0A000003, 32'h0A000004, 16'd6000);
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h50};
      send_payload(pl, 1'b1, 1'b0);
      done = 1'b0;
      for (int n = 0; n < TIMEOUT && !done; n++) begin
         @(negedge clk);
         if (tx_beats_seen >= base + 3) done = 1'b1;
      end
      if (!done) fail_now("tx_partial_timeout", "reply beats did not start");
      @(posedge clk);
      #1;
      reset = 1'b1;
      reset_checks("rst_txpay");
      pl = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
      run_datagram(4324, pl, 1'b1);

      // Randomized traffic across and around the port window
      for (int t = 0; t < 30; t++) begin
         int len = 1 + int'($urandom % 20);
         pl.delete();
         for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
         run_datagram(4319 + int'($urandom % 8), pl, ($urandom % 4) == 0);
      end

      check("final_out_q_empty", 64'(out_q.size()), 64'(0));
      check("final_tx_q_empty",  64'(tx_q.size()),  64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
